// File: rtl/csr_reg.sv
// Machine-mode CSR file for a single-hart RV64 core: trap CSRs, cycle/instret counters and gated interrupt requests.
// Define CSR_TIMER_EN to add an internal mtime (0x7C0) / mtimecmp (0x7C1) timer that drives MTIP instead of tmr_irq_src_i.
module csr_reg #(
   parameter int              XLEN   = 64,
   parameter logic [XLEN-1:0] HARTID = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_waddr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   input  logic [11:0]     csr_raddr_i,
   output logic [XLEN-1:0] csr_rdata_o,
   input  logic            clint_we_i,
   input  logic [11:0]     clint_addr_i,
   input  logic [XLEN-1:0] clint_data_i,
   output logic [XLEN-1:0] clint_data_o,
   output logic [XLEN-1:0] csr_mtvec_o,
   output logic [XLEN-1:0] csr_mepc_o,
   output logic [XLEN-1:0] csr_mstatus_o,
   output logic            glb_irqen_o,
   output logic            tmr_irq_o,
   output logic            ext_irq_o,
   input  logic            ext_irq_src_i,
   input  logic            tmr_irq_src_i,
   input  logic            instr_retire_i
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
   localparam logic [11:0] ADDR_MTIME    = 12'h7C0;
   localparam logic [11:0] ADDR_MTIMECMP = 12'h7C1;

   localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(64'h88);
   localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'(64'h1800);
   localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(64'h880);
   localparam logic [XLEN-1:0] ALIGN_MASK    = ~XLEN'(3);

   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mie_q, mie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mcycle_q, mcycle_d;
   logic [XLEN-1:0] minstret_q, minstret_d;
   logic            meip_q, meip_d;
   logic            mtip_q, mtip_d;
`ifdef CSR_TIMER_EN
   logic [XLEN-1:0] mtime_q, mtime_d;
   logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
   logic            unused_tmr_src;
   assign unused_tmr_src = tmr_irq_src_i;
`endif

   logic            wr_en   [2];
   logic [11:0]     wr_addr [2];
   logic [XLEN-1:0] wr_data [2];
   logic [11:0]     rd_addr [2];
   logic [XLEN-1:0] rd_data [2];

   // Port 1 is the interrupt controller; being applied last, it overrides a same-address pipeline write.
   assign wr_en[0]   = csr_we_i;
   assign wr_addr[0] = csr_waddr_i;
   assign wr_data[0] = csr_wdata_i;
   assign wr_en[1]   = clint_we_i;
   assign wr_addr[1] = clint_addr_i;
   assign wr_data[1] = clint_data_i;

   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mcycle_d   = mcycle_q + XLEN'(1);
      minstret_d = minstret_q + XLEN'(instr_retire_i);
      meip_d     = ext_irq_src_i;
`ifdef CSR_TIMER_EN
      mtime_d    = mtime_q + XLEN'(1);
      mtimecmp_d = mtimecmp_q;
      mtip_d     = (mtime_q >= mtimecmp_q);
`else
      mtip_d     = tmr_irq_src_i;
`endif
      for (int i = 0; i < 2; i++) begin
         if (wr_en[i]) begin
            case (wr_addr[i])
               ADDR_MSTATUS:  mstatus_d  = (wr_data[i] & MSTATUS_WMASK) | MSTATUS_FIXED;
               ADDR_MIE:      mie_d      = wr_data[i] & MIE_WMASK;
               ADDR_MTVEC:    mtvec_d    = wr_data[i] & ALIGN_MASK;
               ADDR_MSCRATCH: mscratch_d = wr_data[i];
               ADDR_MEPC:     mepc_d     = wr_data[i] & ALIGN_MASK;
               ADDR_MCAUSE:   mcause_d   = wr_data[i];
               ADDR_MCYCLE:   mcycle_d   = wr_data[i];
               ADDR_MINSTRET: minstret_d = wr_data[i];
`ifdef CSR_TIMER_EN
               ADDR_MTIME:    mtime_d    = wr_data[i];
               ADDR_MTIMECMP: mtimecmp_d = wr_data[i];
`endif
               default: ;
            endcase
         end
      end
   end

   assign rd_addr[0] = csr_raddr_i;
   assign rd_addr[1] = clint_addr_i;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rd_data[i] = '0;
         case (rd_addr[i])
            ADDR_MSTATUS:  rd_data[i] = mstatus_q;
            ADDR_MIE:      rd_data[i] = mie_q;
            ADDR_MTVEC:    rd_data[i] = mtvec_q;
            ADDR_MSCRATCH: rd_data[i] = mscratch_q;
            ADDR_MEPC:     rd_data[i] = mepc_q;
            ADDR_MCAUSE:   rd_data[i] = mcause_q;
            ADDR_MIP:      rd_data[i] = (XLEN'(meip_q) << 11) | (XLEN'(mtip_q) << 7);
            ADDR_MCYCLE:   rd_data[i] = mcycle_q;
            ADDR_MINSTRET: rd_data[i] = minstret_q;
            ADDR_MHARTID:  rd_data[i] = HARTID;
`ifdef CSR_TIMER_EN
            ADDR_MTIME:    rd_data[i] = mtime_q;
            ADDR_MTIMECMP: rd_data[i] = mtimecmp_q;
`endif
            default:       rd_data[i] = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_q  <= MSTATUS_FIXED;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
         meip_q     <= 1'b0;
         mtip_q     <= 1'b0;
`ifdef CSR_TIMER_EN
         mtime_q    <= '0;
         mtimecmp_q <= '1;
`endif
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         meip_q     <= meip_d;
         mtip_q     <= mtip_d;
`ifdef CSR_TIMER_EN
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
`endif
      end
   end

   assign csr_rdata_o   = rd_data[0];
   assign clint_data_o  = rd_data[1];
   assign csr_mtvec_o   = mtvec_q;
   assign csr_mepc_o    = mepc_q;
   assign csr_mstatus_o = mstatus_q;
   assign glb_irqen_o   = mstatus_q[3];
   assign tmr_irq_o     = mtip_q & mie_q[7] & mstatus_q[3];
   assign ext_irq_o     = meip_q & mie_q[11] & mstatus_q[3];

endmodule
